// File: rtl/edge_detect_pkg.sv
// Shared constants for the multi-channel edge detector: output mode encoding,
// parameter legality check and filter counter sizing.
package edge_detect_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    function automatic bit params_legal(input int ch, input int sync_stages,
                                        input int filt_len, input int cnt_w);
        return (ch >= 32'sd1) && (sync_stages >= 32'sd2) &&
               (filt_len >= 32'sd1) && (cnt_w >= 32'sd1);
    endfunction

    // A one-cycle filter never counts, but still needs a one-bit counter.
    function automatic int fcnt_width(input int filt_len);
        return (filt_len > 32'sd1) ? $clog2(filt_len) : 32'sd1;
    endfunction

endpackage

// File: rtl/edge_detect_ch.sv
// One channel of the edge detector: synchroniser, persistence filter,
// enable-gated rise/fall pulses and a saturating event counter.
module edge_detect_ch
    import edge_detect_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int CNT_W       = 8
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic             data_in,
    input  logic             ch_en,
    input  logic [1:0]       mode,
    input  logic             cnt_clr,
    output logic             rise_edge,
    output logic             fall_edge,
    output logic             edge_pulse,
    output logic             edge_nxt,
    output logic             level,
    output logic [CNT_W-1:0] evt_cnt
);

    localparam int               FCNT_W    = fcnt_width(FILT_LEN);
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILT_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [SYNC_STAGES-1:0] sync_r;
    logic [FCNT_W-1:0]      fcnt_r;
    logic                   level_r;
    logic                   rise_r;
    logic                   fall_r;
    logic                   edge_r;
    logic [CNT_W-1:0]       cnt_r;

    logic                   sync_out_s;
    logic                   update_s;
    logic                   rise_nxt_s;
    logic                   fall_nxt_s;
    logic                   edge_nxt_s;

    assign sync_out_s = sync_r[SYNC_STAGES-1];
    assign update_s   = (sync_out_s != level_r) && (fcnt_r == FCNT_LAST);

    // Metastability chain for the asynchronous raw input.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], data_in};
        end
    end

    // New level must persist FILT_LEN consecutive cycles; any return restarts.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            fcnt_r  <= '0;
            level_r <= 1'b0;
        end else if (sync_out_s == level_r) begin
            fcnt_r  <= '0;
        end else if (update_s) begin
            level_r <= sync_out_s;
            fcnt_r  <= '0;
        end else begin
            fcnt_r  <= fcnt_r + FCNT_W'(1'b1);
        end
    end

    // Gate the level update into pulses and apply the mode selection.
    always_comb begin
        rise_nxt_s = update_s & sync_out_s & ch_en;
        fall_nxt_s = update_s & ~sync_out_s & ch_en;
        case (mode)
            MODE_OFF:  edge_nxt_s = 1'b0;
            MODE_RISE: edge_nxt_s = rise_nxt_s;
            MODE_FALL: edge_nxt_s = fall_nxt_s;
            MODE_BOTH: edge_nxt_s = rise_nxt_s | fall_nxt_s;
            default:   edge_nxt_s = 1'b0;
        endcase
    end

    // Pulses register in the same cycle as the level update.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            rise_r <= 1'b0;
            fall_r <= 1'b0;
            edge_r <= 1'b0;
        end else begin
            rise_r <= rise_nxt_s;
            fall_r <= fall_nxt_s;
            edge_r <= edge_nxt_s;
        end
    end

    // Event counter: clear has priority over a coincident pulse; no wrap.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (cnt_clr) begin
            cnt_r <= '0;
        end else if (edge_nxt_s && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
        end
    end

    assign rise_edge  = rise_r;
    assign fall_edge  = fall_r;
    assign edge_pulse = edge_r;
    assign edge_nxt   = edge_nxt_s;
    assign level      = level_r;
    assign evt_cnt    = cnt_r;

endmodule

// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector: CH independent channels plus a registered
// any-edge flag aligned with the per-channel edge pulses.
module edge_detect_multi
    import edge_detect_pkg::*;
#(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int CNT_W       = 8
) (
    input  logic                sclk,
    input  logic                rst,
    input  logic [CH-1:0]       i_data_in,
    input  logic [CH-1:0]       i_ch_en,
    input  logic [1:0]          i_mode,
    input  logic                i_cnt_clr,
    output logic [CH-1:0]       o_rise_edge,
    output logic [CH-1:0]       o_fall_edge,
    output logic [CH-1:0]       o_edge,
    output logic                o_edge_any,
    output logic [CH-1:0]       o_level,
    output logic [CH*CNT_W-1:0] o_evt_cnt
);

    logic [CH-1:0] edge_nxt_s;
    logic          edge_any_r;

    if (!params_legal(CH, SYNC_STAGES, FILT_LEN, CNT_W)) begin : g_param_check
        $error("edge_detect_multi: illegal parameter set");
    end

    for (genvar k = 0; k < CH; k++) begin : g_ch
        edge_detect_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_LEN    (FILT_LEN),
            .CNT_W       (CNT_W)
        ) u_ch (
            .sclk       (sclk),
            .rst        (rst),
            .data_in    (i_data_in[k]),
            .ch_en      (i_ch_en[k]),
            .mode       (i_mode),
            .cnt_clr    (i_cnt_clr),
            .rise_edge  (o_rise_edge[k]),
            .fall_edge  (o_fall_edge[k]),
            .edge_pulse (o_edge[k]),
            .edge_nxt   (edge_nxt_s[k]),
            .level      (o_level[k]),
            .evt_cnt    (o_evt_cnt[k*CNT_W +: CNT_W])
        );
    end

    // OR of the next-cycle edges so the flag lines up with the o_edge register.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            edge_any_r <= 1'b0;
        end else begin
            edge_any_r <= |edge_nxt_s;
        end
    end

    assign o_edge_any = edge_any_r;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Randomised and directed bench for edge_detect_multi (CNT_W 8 and 2) against
// a history-based reference model of the synchroniser and persistence filter.
module tb_edge_detect_multi;

    localparam int CH = 4;
    localparam int SS = 2;
    localparam int FL = 4;

    logic          sclk = 1'b0;
    logic          rst;
    logic [CH-1:0] data_in;
    logic [CH-1:0] ch_en;
    logic [1:0]    mode;
    logic          cnt_clr;

    logic [CH-1:0]   rise_a, fall_a, edge_a, level_a;
    logic            any_a;
    logic [CH*8-1:0] cnt_a;
    logic [CH-1:0]   rise_b, fall_b, edge_b, level_b;
    logic            any_b;
    logic [CH*2-1:0] cnt_b;

    int n_checks = 0;
    int n_fail   = 0;
    int seen_rise[CH];
    int seen_fall[CH];
    int seen_edge[CH];

    // Reference model state
    logic [CH-1:0] raw_q[$];
    logic [CH-1:0] filt_q[$];
    int            m_age[CH];
    logic [CH-1:0] m_level, m_rise, m_fall, m_edge;
    logic          m_any;
    int unsigned   m_cnt8[CH];
    int unsigned   m_cnt2[CH];

    always #5 sclk = ~sclk;

    edge_detect_multi u_dut (
        .sclk(sclk), .rst(rst), .i_data_in(data_in), .i_ch_en(ch_en),
        .i_mode(mode), .i_cnt_clr(cnt_clr), .o_rise_edge(rise_a),
        .o_fall_edge(fall_a), .o_edge(edge_a), .o_edge_any(any_a),
        .o_level(level_a), .o_evt_cnt(cnt_a)
    );

    edge_detect_multi #(.CNT_W(2)) u_dut_w2 (
        .sclk(sclk), .rst(rst), .i_data_in(data_in), .i_ch_en(ch_en),
        .i_mode(mode), .i_cnt_clr(cnt_clr), .o_rise_edge(rise_b),
        .o_fall_edge(fall_b), .o_edge(edge_b), .o_edge_any(any_b),
        .o_level(level_b), .o_evt_cnt(cnt_b)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        raw_q  = {};
        filt_q = {};
        for (int i = 0; i < SS; i++) raw_q.push_back('0);
        for (int k = 0; k < CH; k++) begin
            m_age[k]  = 0;
            m_cnt8[k] = 0;
            m_cnt2[k] = 0;
        end
        m_level = '0;
        m_rise  = '0;
        m_fall  = '0;
        m_edge  = '0;
        m_any   = 1'b0;
    endtask

    // Level flips once the last FL filter samples all differ from it and
    // no flip happened within those FL cycles.
    task automatic model_step();
        logic [CH-1:0] s;
        bit flip;
        if (rst) begin
            model_reset();
            return;
        end
        raw_q.push_back(data_in);
        s = raw_q.pop_front();
        filt_q.push_back(s);
        if (filt_q.size() > FL) void'(filt_q.pop_front());
        m_rise = '0;
        m_fall = '0;
        m_edge = '0;
        for (int k = 0; k < CH; k++) begin
            m_age[k]++;
            flip = (m_age[k] >= FL);
            foreach (filt_q[j]) if (filt_q[j][k] == m_level[k]) flip = 1'b0;
            if (flip) begin
                m_level[k] = s[k];
                m_age[k]   = 0;
                m_rise[k]  = s[k] & ch_en[k];
                m_fall[k]  = ~s[k] & ch_en[k];
            end
            m_edge[k] = (m_rise[k] && (mode inside {2'b01, 2'b11})) ||
                        (m_fall[k] && (mode inside {2'b10, 2'b11}));
            if (cnt_clr) begin
                m_cnt8[k] = 0;
                m_cnt2[k] = 0;
            end else if (m_edge[k]) begin
                if (m_cnt8[k] < 255) m_cnt8[k]++;
                if (m_cnt2[k] < 3)   m_cnt2[k]++;
            end
        end
        m_any = |m_edge;
    endtask

    task automatic clear_seen();
        for (int k = 0; k < CH; k++) begin
            seen_rise[k] = 0;
            seen_fall[k] = 0;
            seen_edge[k] = 0;
        end
    endtask

    task automatic step(input int n);
        logic [CH*8-1:0] exp8;
        logic [CH*2-1:0] exp2;
        repeat (n) begin
            @(posedge sclk);
            model_step();
            @(negedge sclk);
            for (int k = 0; k < CH; k++) begin
                exp8[k*8 +: 8] = m_cnt8[k][7:0];
                exp2[k*2 +: 2] = m_cnt2[k][1:0];
            end
            check_val("rise_a",  rise_a,  m_rise);
            check_val("fall_a",  fall_a,  m_fall);
            check_val("edge_a",  edge_a,  m_edge);
            check_val("any_a",   any_a,   m_any);
            check_val("level_a", level_a, m_level);
            check_val("cnt_a",   cnt_a,   exp8);
            check_val("rise_b",  rise_b,  m_rise);
            check_val("edge_b",  edge_b,  m_edge);
            check_val("any_b",   any_b,   m_any);
            check_val("cnt_b",   cnt_b,   exp2);
            for (int k = 0; k < CH; k++) begin
                seen_rise[k] += int'(rise_a[k]);
                seen_fall[k] += int'(fall_a[k]);
                seen_edge[k] += int'(edge_a[k]);
            end
        end
    endtask

    // Bounded search for the first rise pulse on the masked channels.
    task automatic wait_rise(input logic [CH-1:0] mask, input int exp_lat, input string tag);
        int            found = 0;
        logic [CH-1:0] val   = '0;
        for (int c = 1; c <= 20; c++) begin
            step(1);
            if (found == 0 && (rise_a & mask) != '0) begin
                found = c;
                val   = rise_a & mask;
            end
        end
        check_val({tag, "_latency"}, 64'(found), 64'(exp_lat));
        check_val({tag, "_pulse"}, 64'(val), 64'(mask));
    endtask

    int exp_edges[4] = '{1, 1, 2, 0};
    logic [1:0] modes[4] = '{2'b01, 2'b10, 2'b11, 2'b00};
    int unsigned saved_cnt;

    initial begin
        rst = 1'b1; data_in = '0; ch_en = '1; mode = 2'b11; cnt_clr = 1'b0;
        model_reset();
        clear_seen();
        step(2);

        // Reset with all inputs high, then full-latency rise on every channel
        data_in = '1;
        step(2);
        check_val("reset_outputs", {rise_a, fall_a, edge_a, level_a, cnt_a}, 64'd0);
        rst = 1'b0;
        wait_rise(4'hF, 6, "reset_release");
        check_val("level_after_release", level_a, 4'hF);

        // Glitch rejection then genuine rise on ch0
        data_in = '0;
        step(10);
        cnt_clr = 1'b1; step(1); cnt_clr = 1'b0;
        clear_seen();
        data_in[0] = 1'b1; step(3); data_in[0] = 1'b0; step(10);
        check_val("glitch_pulses", seen_rise[0], 0);
        check_val("glitch_level", level_a[0], 1'b0);
        data_in[0] = 1'b1; step(10);
        check_val("held_pulses", seen_rise[0], 1);
        check_val("held_cnt", cnt_a[7:0], 8'd1);

        // Mode selection on ch1
        for (int m = 0; m < 4; m++) begin
            mode = modes[m];
            clear_seen();
            data_in[1] = 1'b1; step(8);
            data_in[1] = 1'b0; step(8);
            check_val($sformatf("mode%0d_edges", m), seen_edge[1], exp_edges[m]);
            check_val($sformatf("mode%0d_rise", m), seen_rise[1], 1);
            check_val($sformatf("mode%0d_fall", m), seen_fall[1], 1);
        end

        // Enable masking on ch2
        mode = 2'b11;
        saved_cnt = m_cnt8[2];
        clear_seen();
        ch_en[2] = 1'b0; data_in[2] = 1'b1; step(8);
        check_val("disabled_pulses", seen_rise[2], 0);
        check_val("disabled_cnt", cnt_a[23:16], saved_cnt[7:0]);
        check_val("disabled_level", level_a[2], 1'b1);
        ch_en[2] = 1'b1; step(8);
        check_val("reenable_pulses", seen_rise[2] + seen_fall[2], 0);
        data_in[2] = 1'b0; step(8);

        // Counter saturation and clear-wins on ch3
        mode = 2'b01;
        cnt_clr = 1'b1; step(1); cnt_clr = 1'b0;
        repeat (5) begin
            data_in[3] = 1'b1; step(7);
            data_in[3] = 1'b0; step(7);
        end
        check_val("sat_w2", cnt_b[7:6], 2'd3);
        check_val("count_w8", cnt_a[31:24], 8'd5);
        data_in[3] = 1'b1; step(5);
        cnt_clr = 1'b1; step(1); cnt_clr = 1'b0;
        check_val("clr_pulse", rise_a[3], 1'b1);
        check_val("clr_wins_w2", cnt_b[7:6], 2'd0);
        check_val("clr_wins_w8", cnt_a[31:24], 8'd0);

        // Reset two cycles into ch0 filtering
        mode = 2'b11;
        data_in[0] = 1'b0; step(10);
        data_in[0] = 1'b1; step(2);
        rst = 1'b1; step(1); rst = 1'b0;
        wait_rise(4'h1, 6, "mid_filter_reset");

        // Random stimulus with occasional enable/mode/clear/reset changes
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < CH; k++)
                if ($urandom_range(0, 5) == 0) data_in[k] = ~data_in[k];
            if ($urandom_range(0, 49) == 0) ch_en = CH'($urandom);
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom);
            cnt_clr = ($urandom_range(0, 79) == 0);
            rst     = ($urandom_range(0, 399) == 0);
            step(1);
        end
        rst = 1'b0; cnt_clr = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
